// File: rtl/decode_pkg.sv
// Shared encodings and control bundle for the ARM decode stage.
package decode_pkg;

   localparam logic [1:0] MODE_ARITH  = 2'b00;
   localparam logic [1:0] MODE_MEM    = 2'b01;
   localparam logic [1:0] MODE_BRANCH = 2'b10;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_TST = 4'b1000;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_MVN = 4'b1111;

   localparam logic [3:0] EXE_NOP = 4'b0000;
   localparam logic [3:0] EXE_MOV = 4'b0001;
   localparam logic [3:0] EXE_ADD = 4'b0010;
   localparam logic [3:0] EXE_ADC = 4'b0011;
   localparam logic [3:0] EXE_SUB = 4'b0100;
   localparam logic [3:0] EXE_SBC = 4'b0101;
   localparam logic [3:0] EXE_AND = 4'b0110;
   localparam logic [3:0] EXE_ORR = 4'b0111;
   localparam logic [3:0] EXE_EOR = 4'b1000;
   localparam logic [3:0] EXE_MVN = 4'b1001;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   typedef struct packed {
      logic [3:0] exe_cmd;
      logic       mem_r_en;
      logic       mem_w_en;
      logic       wb_en;
      logic       s;
      logic       b;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational mode/opcode/s decode into the control bundle; no state.
module decode_ctrl
   import decode_pkg::*;
(
   input  logic [1:0] mode,
   input  logic [3:0] opcode,
   input  logic       s_in,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = CTRL_NOP;
      case (mode)
         MODE_ARITH: begin
            ctrl.s     = s_in;
            ctrl.wb_en = 1'b1;
            case (opcode)
               OP_MOV: ctrl.exe_cmd = EXE_MOV;
               OP_MVN: ctrl.exe_cmd = EXE_MVN;
               OP_ADD: ctrl.exe_cmd = EXE_ADD;
               OP_ADC: ctrl.exe_cmd = EXE_ADC;
               OP_SUB: ctrl.exe_cmd = EXE_SUB;
               OP_SBC: ctrl.exe_cmd = EXE_SBC;
               OP_AND: ctrl.exe_cmd = EXE_AND;
               OP_ORR: ctrl.exe_cmd = EXE_ORR;
               OP_EOR: ctrl.exe_cmd = EXE_EOR;
               OP_CMP: begin
                  ctrl.exe_cmd = EXE_SUB;
                  ctrl.wb_en   = 1'b0;
               end
               OP_TST: begin
                  ctrl.exe_cmd = EXE_AND;
                  ctrl.wb_en   = 1'b0;
               end
               default: ctrl.wb_en = 1'b0;
            endcase
         end
         MODE_MEM: begin
            // address is always rn + offset; s_in selects load vs store
            ctrl.exe_cmd = EXE_ADD;
            if (s_in) begin
               ctrl.mem_r_en = 1'b1;
               ctrl.wb_en    = 1'b1;
            end else begin
               ctrl.mem_w_en = 1'b1;
            end
         end
         MODE_BRANCH: ctrl.b = 1'b1;
         default: ctrl = CTRL_NOP;
      endcase
   end

endmodule

// File: rtl/decode_stage_p.sv
// ID stage: decode, condition check and register read into a 1-cycle ID/EXE register with valid/ready.
// Optional DECODE_WB_BYPASS_EN makes register-file reads write-first.
module decode_stage_p
   import decode_pkg::*;
#(
   parameter  int DATA_W   = 32,
   parameter  int PC_W     = 32,
   parameter  int NUM_REGS = 16,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   pc_in,
   input  logic [31:0]       instruction,
   input  logic [3:0]        sr,
   input  logic              hazard,
   input  logic              flush,
   input  logic              wb_wb_en,
   input  logic [ADDR_W-1:0] wb_dest,
   input  logic [DATA_W-1:0] wb_value,
   output logic [ADDR_W-1:0] src_1_id,
   output logic [ADDR_W-1:0] src_2_id,
   output logic              two_src_id,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              wb_en,
   output logic              mem_r_en,
   output logic              mem_w_en,
   output logic              b,
   output logic              s,
   output logic              imm,
   output logic              two_src,
   output logic [3:0]        exe_cmd,
   output logic [ADDR_W-1:0] dest,
   output logic [ADDR_W-1:0] src_1,
   output logic [ADDR_W-1:0] src_2,
   output logic [11:0]       shift_operand,
   output logic [23:0]       imm_signed_24,
   output logic [PC_W-1:0]   pc,
   output logic [DATA_W-1:0] value_rn,
   output logic [DATA_W-1:0] value_rm
);

   logic [3:0]        cond;
   logic [1:0]        mode;
   logic [3:0]        opcode;
   logic              s_in;
   logic              imm_bit;
   logic              store;
   logic [ADDR_W-1:0] rn, rd, rm;
   ctrl_t             ctrl_dec;
   logic              cond_ok;

   assign cond    = instruction[31:28];
   assign mode    = instruction[27:26];
   assign imm_bit = instruction[25];
   assign opcode  = instruction[24:21];
   assign s_in    = instruction[20];
   assign rn      = instruction[16 +: ADDR_W];
   assign rd      = instruction[12 +: ADDR_W];
   assign rm      = instruction[0  +: ADDR_W];
   assign store   = (mode == MODE_MEM) & ~s_in;

   assign src_1_id   = rn;
   assign src_2_id   = store ? rd : rm;
   assign two_src_id = ~imm_bit | store;

   decode_ctrl u_ctrl (
      .mode   (mode),
      .opcode (opcode),
      .s_in   (s_in),
      .ctrl   (ctrl_dec)
   );

   // sr = {N,Z,C,V}; 1111 is never executed
   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         COND_EQ: cond_ok = sr[2];
         COND_NE: cond_ok = ~sr[2];
         COND_CS: cond_ok = sr[1];
         COND_CC: cond_ok = ~sr[1];
         COND_MI: cond_ok = sr[3];
         COND_PL: cond_ok = ~sr[3];
         COND_VS: cond_ok = sr[0];
         COND_VC: cond_ok = ~sr[0];
         COND_HI: cond_ok = sr[1] & ~sr[2];
         COND_LS: cond_ok = ~sr[1] | sr[2];
         COND_GE: cond_ok = (sr[3] == sr[0]);
         COND_LT: cond_ok = (sr[3] != sr[0]);
         COND_GT: cond_ok = ~sr[2] & (sr[3] == sr[0]);
         COND_LE: cond_ok = sr[2] | (sr[3] != sr[0]);
         COND_AL: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] rd_rn, rd_rm;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wb_wb_en) begin
         regs[wb_dest] <= wb_value;
      end
   end

`ifdef DECODE_WB_BYPASS_EN
   assign rd_rn = (wb_wb_en && wb_dest == rn)       ? wb_value : regs[rn];
   assign rd_rm = (wb_wb_en && wb_dest == src_2_id) ? wb_value : regs[src_2_id];
`else
   assign rd_rn = regs[rn];
   assign rd_rm = regs[src_2_id];
`endif

   logic  xfer;
   logic  exe_accepts;
   ctrl_t ctrl_q;

   // flush always consumes the incoming slot, even over a hazard
   assign in_ready    = (~hazard & (~out_valid | out_ready)) | flush;
   assign xfer        = in_valid & in_ready;
   assign exe_accepts = out_ready | ~out_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid     <= 1'b0;
         ctrl_q        <= CTRL_NOP;
         imm           <= 1'b0;
         two_src       <= 1'b0;
         dest          <= '0;
         src_1         <= '0;
         src_2         <= '0;
         shift_operand <= '0;
         imm_signed_24 <= '0;
         pc            <= '0;
         value_rn      <= '0;
         value_rm      <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         ctrl_q    <= CTRL_NOP;
         imm       <= 1'b0;
         two_src   <= 1'b0;
      end else if (xfer) begin
         out_valid     <= 1'b1;
         ctrl_q        <= cond_ok ? ctrl_dec : CTRL_NOP;
         imm           <= imm_bit;
         two_src       <= two_src_id;
         dest          <= rd;
         src_1         <= rn;
         src_2         <= src_2_id;
         shift_operand <= instruction[11:0];
         imm_signed_24 <= instruction[23:0];
         pc            <= pc_in;
         value_rn      <= rd_rn;
         value_rm      <= rd_rm;
      end else if (exe_accepts) begin
         out_valid <= 1'b0;
         ctrl_q    <= CTRL_NOP;
         imm       <= 1'b0;
         two_src   <= 1'b0;
      end else begin
         // stalled by EXE: keep operands coherent with writeback
         if (wb_wb_en && wb_dest == src_1) value_rn <= wb_value;
         if (wb_wb_en && wb_dest == src_2) value_rm <= wb_value;
      end
   end

   assign exe_cmd  = ctrl_q.exe_cmd;
   assign mem_r_en = ctrl_q.mem_r_en;
   assign mem_w_en = ctrl_q.mem_w_en;
   assign wb_en    = ctrl_q.wb_en;
   assign s        = ctrl_q.s;
   assign b        = ctrl_q.b;

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed scoreboard bench for decode_stage_p (default parameters).
module tb_decode_stage_p;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] pc_in;
   logic [31:0] instruction;
   logic [3:0]  sr;
   logic        hazard;
   logic        flush;
   logic        wb_wb_en;
   logic [3:0]  wb_dest;
   logic [31:0] wb_value;
   logic [3:0]  src_1_id, src_2_id;
   logic        two_src_id;
   logic        out_valid;
   logic        out_ready;
   logic        wb_en, mem_r_en, mem_w_en, b, s, imm, two_src;
   logic [3:0]  exe_cmd;
   logic [3:0]  dest, src_1, src_2;
   logic [11:0] shift_operand;
   logic [23:0] imm_signed_24;
   logic [31:0] pc;
   logic [31:0] value_rn, value_rm;

   decode_stage_p dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .pc_in         (pc_in),
      .instruction   (instruction),
      .sr            (sr),
      .hazard        (hazard),
      .flush         (flush),
      .wb_wb_en      (wb_wb_en),
      .wb_dest       (wb_dest),
      .wb_value      (wb_value),
      .src_1_id      (src_1_id),
      .src_2_id      (src_2_id),
      .two_src_id    (two_src_id),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .wb_en         (wb_en),
      .mem_r_en      (mem_r_en),
      .mem_w_en      (mem_w_en),
      .b             (b),
      .s             (s),
      .imm           (imm),
      .two_src       (two_src),
      .exe_cmd       (exe_cmd),
      .dest          (dest),
      .src_1         (src_1),
      .src_2         (src_2),
      .shift_operand (shift_operand),
      .imm_signed_24 (imm_signed_24),
      .pc            (pc),
      .value_rn      (value_rn),
      .value_rm      (value_rm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  exe_cmd;
      logic        wb_en, mem_r_en, mem_w_en, b, s, imm, two_src;
      logic [3:0]  dest, src_1, src_2;
      logic [31:0] pc, vrn, vrm;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   function automatic exp_t mk(input logic [3:0] e, input logic w, input logic mr, input logic mw,
                               input logic bb, input logic ss, input logic im, input logic ts,
                               input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2,
                               input logic [31:0] p, input logic [31:0] vn, input logic [31:0] vm);
      exp_t x;
      x.exe_cmd = e;  x.wb_en = w;   x.mem_r_en = mr; x.mem_w_en = mw;
      x.b = bb;       x.s = ss;      x.imm = im;      x.two_src = ts;
      x.dest = d;     x.src_1 = s1;  x.src_2 = s2;
      x.pc = p;       x.vrn = vn;    x.vrm = vm;
      return x;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_pop(input string tag);
      exp_t e;
      n_assert++;
      assert (sb.size() > 0) else begin
         n_fail++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_valid"},   32'(out_valid), 32'd1);
         chk({tag, "_exe"},     32'(exe_cmd),   32'(e.exe_cmd));
         chk({tag, "_wb_en"},   32'(wb_en),     32'(e.wb_en));
         chk({tag, "_mem_r"},   32'(mem_r_en),  32'(e.mem_r_en));
         chk({tag, "_mem_w"},   32'(mem_w_en),  32'(e.mem_w_en));
         chk({tag, "_b"},       32'(b),         32'(e.b));
         chk({tag, "_s"},       32'(s),         32'(e.s));
         chk({tag, "_imm"},     32'(imm),       32'(e.imm));
         chk({tag, "_two_src"}, 32'(two_src),   32'(e.two_src));
         chk({tag, "_dest"},    32'(dest),      32'(e.dest));
         chk({tag, "_src_1"},   32'(src_1),     32'(e.src_1));
         chk({tag, "_src_2"},   32'(src_2),     32'(e.src_2));
         chk({tag, "_pc"},      pc,             e.pc);
         chk({tag, "_rn"},      value_rn,       e.vrn);
         chk({tag, "_rm"},      value_rm,       e.vrm);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic ordy, input logic haz, input logic fl,
                        input logic wbe, input logic [3:0] wbd, input logic [31:0] wbv);
      in_valid    = v;
      instruction = ins;
      pc_in       = p;
      out_ready   = ordy;
      hazard      = haz;
      flush       = fl;
      wb_wb_en    = wbe;
      wb_dest     = wbd;
      wb_value    = wbv;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] str_rm;
`ifdef DECODE_WB_BYPASS_EN
      str_rm = 32'hAB;
`else
      str_rm = 32'h33;
`endif
      rst = 1'b0;
      sr  = 4'b0000;
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_exe_cmd",   32'(exe_cmd),   32'd0);
      chk("rst_wb_en",     32'(wb_en),     32'd0);
      chk("rst_dest",      32'(dest),      32'd0);
      chk("rst_pc",        pc,             32'd0);
      chk("rst_value_rn",  value_rn,       32'd0);
      tick(); tick();
      rst = 1'b1;

      // preload R2, R3 through writeback
      tick(); drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 32'h22);
      tick(); drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 32'h33);

      // ADD R1,R2,R3
      tick(); drive(1'b1, 32'hE0821003, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0); #2;
      chk("add_src_1_id",   32'(src_1_id),   32'd2);
      chk("add_src_2_id",   32'(src_2_id),   32'd3);
      chk("add_two_src_id", 32'(two_src_id), 32'd1);
      chk("add_in_ready",   32'(in_ready),   32'd1);
      chk("idle_out_valid", 32'(out_valid),  32'd0);
      sb.push_back(mk(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                      4'd1, 4'd2, 4'd3, 32'h100, 32'h22, 32'h33));

      // MOVNE R5,#7 with Z=1: nulled but still valid
      tick(); sr = 4'b0100;
      drive(1'b1, 32'h13A05007, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0); #2;
      check_pop("add");
      sb.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                      4'd5, 4'd0, 4'd7, 32'h104, 32'h0, 32'h0));

      // ADD R4,R2,R3 then back-pressure
      tick(); sr = 4'b0000;
      drive(1'b1, 32'hE0824003, 32'h108, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0); #2;
      chk("movne_shift", 32'(shift_operand), 32'h007);
      check_pop("movne");
      sb.push_back(mk(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                      4'd4, 4'd2, 4'd3, 32'h108, 32'h22, 32'h33));

      tick(); drive(1'b1, 32'hE0027003, 32'h10C, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 32'h55); #2;
      chk("bp0_in_ready",  32'(in_ready),  32'd0);
      chk("bp0_out_valid", 32'(out_valid), 32'd1);
      chk("bp0_value_rn",  value_rn,       32'h22);
      sb[0].vrn = 32'h55;
      for (int k = 0; k < 2; k++) begin
         tick(); drive(1'b1, 32'hE0027003, 32'h10C, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0); #2;
         chk("bp_in_ready",  32'(in_ready),  32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_value_rn",  value_rn,       sb[0].vrn);
         chk("bp_dest",      32'(dest),      32'd4);
         chk("bp_pc",        pc,             32'h108);
      end
      tick(); drive(1'b1, 32'hE0027003, 32'h10C, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0); #2;
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      check_pop("add_held");
      sb.push_back(mk(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                      4'd7, 4'd2, 4'd3, 32'h10C, 32'h55, 32'h33));

      // one-cycle hazard on EOR R8,R2,R3
      tick(); drive(1'b1, 32'hE0228003, 32'h110, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0); #2;
      chk("haz_in_ready", 32'(in_ready), 32'd0);
      check_pop("and");
      tick(); drive(1'b1, 32'hE0228003, 32'h110, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0); #2;
      chk("haz_bubble",        32'(out_valid), 32'd0);
      chk("haz_after_in_ready", 32'(in_ready), 32'd1);
      sb.push_back(mk(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                      4'd8, 4'd2, 4'd3, 32'h110, 32'h55, 32'h33));

      // flush together with hazard drops SUB R9
      tick(); drive(1'b1, 32'hE0429003, 32'h114, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0); #2;
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      check_pop("eor");
      tick(); drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0); #2;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_exe_cmd",   32'(exe_cmd),   32'd0);
      chk("flush_wb_en",     32'(wb_en),     32'd0);

      // STR R3,[R2] while writeback updates R3
      tick(); drive(1'b1, 32'hE5823000, 32'h118, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 32'hAB); #2;
      chk("str_src_2_id",   32'(src_2_id),   32'd3);
      chk("str_two_src_id", 32'(two_src_id), 32'd1);
      sb.push_back(mk(4'b0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                      4'd3, 4'd2, 4'd3, 32'h118, 32'h55, str_rm));

      // LDR R10,[R3,#4] with S set: s must stay 0
      tick(); drive(1'b1, 32'hE793A004, 32'h11C, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0); #2;
      chk("ldr_two_src_id", 32'(two_src_id), 32'd0);
      check_pop("str");
      sb.push_back(mk(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                      4'd10, 4'd3, 4'd4, 32'h11C, 32'hAB, 32'h0));

      // BEQ with Z=1
      tick(); sr = 4'b0100;
      drive(1'b1, 32'h0A000010, 32'h120, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0); #2;
      check_pop("ldr");
      sb.push_back(mk(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                      4'd0, 4'd0, 4'd0, 32'h120, 32'h0, 32'h0));

      // CMP R2,R3 (S=1, no writeback)
      tick(); sr = 4'b0000;
      drive(1'b1, 32'hE1520003, 32'h124, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0); #2;
      chk("b_imm24", 32'(imm_signed_24), 32'h10);
      check_pop("b");
      sb.push_back(mk(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                      4'd0, 4'd2, 4'd3, 32'h124, 32'h55, 32'hAB));

      tick(); drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0); #2;
      check_pop("cmp");

      // reset during a hold discards the held instruction
      tick(); drive(1'b1, 32'hE0821003, 32'h128, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0); #2;
      chk("pre_hold_out_valid", 32'(out_valid), 32'd0);
      tick(); drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0); #2;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_pc",        pc,             32'h128);
      rst = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_pc",        pc,             32'd0);
      chk("mid_rst_value_rn",  value_rn,       32'd0);
      chk("mid_rst_exe_cmd",   32'(exe_cmd),   32'd0);
      tick();
      rst = 1'b1;
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
